// File: rtl/aes_host_pkg.sv
// -----------------------------------------------------------------------------
// aes_host_pkg
// Shared definitions for the aes_core host sequencer:
//   - host_state_e : sequencer FSM states
//   - op_mode constants  (ENCRYPTION, KEY_DERIVATION, DECRYPTION, DECRYP_W_DERIV)
//   - aes_mode constants (ECB, CBC, CTR)
//   - beat_strobe()      : one-hot word strobe for a 2-bit load beat index
// -----------------------------------------------------------------------------
package aes_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_IV,
        ST_DATA,
        ST_START,
        ST_WAIT,
        ST_RESP
    } host_state_e;

    localparam logic [1:0] ENCRYPTION     = 2'b00;
    localparam logic [1:0] KEY_DERIVATION = 2'b01;
    localparam logic [1:0] DECRYPTION     = 2'b10;
    localparam logic [1:0] DECRYP_W_DERIV = 2'b11;

    localparam logic [1:0] ECB = 2'b00;
    localparam logic [1:0] CBC = 2'b01;
    localparam logic [1:0] CTR = 2'b10;

    // Beat 0 carries the most significant word and selects strobe bit 0.
    function automatic logic [3:0] beat_strobe(input logic [1:0] beat);
        return 4'b0001 << beat;
    endfunction

endpackage

// File: rtl/aes_host_word_shift.sv
// -----------------------------------------------------------------------------
// aes_host_word_shift
// 128-bit operand register presenting one 32-bit word at a time, MSB word
// first. A load replaces the whole operand; each shift advances one word and
// fills zeros behind, so after the fourth shift the word output is zero.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears the register)
//   load        : capture load_value (takes priority over shift)
//   shift       : advance to the next word
//   load_value  : 128-bit operand to present
//   word        : current word (registered)
// -----------------------------------------------------------------------------
module aes_host_word_shift (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [127:0] load_value,
    output logic [31:0]  word
);

    logic [127:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= load_value;
        end else if (shift) begin
            shift_reg <= {shift_reg[95:0], 32'h0};
        end
    end

    assign word = shift_reg[127:96];

endmodule

// File: rtl/aes_host_sequencer.sv
// -----------------------------------------------------------------------------
// aes_host_sequencer
// Host-side initiator for aes_core's 32-bit load bus. Accepts one job over a
// valid/ready handshake, serializes key / IV / data words onto the core's
// strobes (4 beats per enabled phase, MSB word first, phases back to back),
// pulses core_start, waits for core_done and returns the 128-bit result over
// a second valid/ready handshake.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_*                      : job handshake and operands
//   core_bus_in, core_key_en,
//   core_iv_en, core_addr,
//   core_write_en              : word load bus towards aes_core
//   core_op_mode, core_aes_mode,
//   core_first_block           : job mode, held from accept to response
//   core_start, core_done,
//   core_dout                  : start pulse, completion and result
//   rsp_valid, rsp_ready,
//   rsp_data, rsp_error        : result handshake
//   busy                       : high whenever the sequencer is not idle
// Optional build macro AES_HOST_TIMEOUT_EN bounds the WAIT state to
// TIMEOUT_CYCLES cycles and then responds with rsp_error=1, rsp_data=0.
// All outputs are registered.
// -----------------------------------------------------------------------------
module aes_host_sequencer
    import aes_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op_mode,
    input  logic [1:0]   req_aes_mode,
    input  logic         req_first_block,
    input  logic         req_load_key,
    input  logic         req_load_iv,
    input  logic         req_load_data,
    input  logic [127:0] req_key,
    input  logic [127:0] req_iv,
    input  logic [127:0] req_data,
    output logic [31:0]  core_bus_in,
    output logic [3:0]   core_key_en,
    output logic [3:0]   core_iv_en,
    output logic [1:0]   core_addr,
    output logic         core_write_en,
    output logic [1:0]   core_op_mode,
    output logic [1:0]   core_aes_mode,
    output logic         core_first_block,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_dout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_error,
    output logic         busy
);

    host_state_e  state;
    host_state_e  next_state;
    logic [1:0]   beat;
    logic [1:0]   next_beat;
    logic         accept;
    logic         load_iv_q;
    logic         load_data_q;
    logic [127:0] iv_q;
    logic [127:0] data_q;
    logic         sh_load;
    logic         sh_shift;
    logic [127:0] sh_value;

`ifdef AES_HOST_TIMEOUT_EN
    logic [31:0]  wait_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // The shifter register itself drives core_bus_in, so the word is already
    // registered and lines up with the strobes registered below.
    aes_host_word_shift u_word_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .shift      (sh_shift),
        .load_value (sh_value),
        .word       (core_bus_in)
    );

    // Next state / beat and shifter control. The key operand goes straight
    // into the shifter at accept; IV and data are reloaded from their holding
    // registers on the last beat of the preceding phase so phases abut.
    always_comb begin
        accept     = req_valid && req_ready;
        next_state = state;
        next_beat  = beat;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_value   = '0;
        case (state)
            ST_IDLE: begin
                next_beat = 2'd0;
                if (accept) begin
                    if (req_load_key) begin
                        next_state = ST_KEY;
                        sh_load    = 1'b1;
                        sh_value   = req_key;
                    end else if (req_load_iv) begin
                        next_state = ST_IV;
                        sh_load    = 1'b1;
                        sh_value   = req_iv;
                    end else if (req_load_data) begin
                        next_state = ST_DATA;
                        sh_load    = 1'b1;
                        sh_value   = req_data;
                    end else begin
                        next_state = ST_START;
                    end
                end
            end
            ST_KEY, ST_IV, ST_DATA: begin
                next_beat = beat + 2'd1;
                sh_shift  = 1'b1;
                if (beat == 2'd3) begin
                    if (state == ST_KEY && load_iv_q) begin
                        next_state = ST_IV;
                        sh_load    = 1'b1;
                        sh_value   = iv_q;
                    end else if (state != ST_DATA && load_data_q) begin
                        next_state = ST_DATA;
                        sh_load    = 1'b1;
                        sh_value   = data_q;
                    end else begin
                        next_state = ST_START;
                    end
                end
            end
            ST_START: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    next_state = ST_RESP;
                end
`ifdef AES_HOST_TIMEOUT_EN
                else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    next_state = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs. Strobes are decoded from the
    // next state/beat so they appear in the same cycle the FSM enters a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            beat             <= 2'd0;
            load_iv_q        <= 1'b0;
            load_data_q      <= 1'b0;
            iv_q             <= '0;
            data_q           <= '0;
            req_ready        <= 1'b0;
            busy             <= 1'b0;
            core_key_en      <= 4'h0;
            core_iv_en       <= 4'h0;
            core_addr        <= 2'd0;
            core_write_en    <= 1'b0;
            core_start       <= 1'b0;
            core_op_mode     <= 2'd0;
            core_aes_mode    <= 2'd0;
            core_first_block <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            rsp_error        <= 1'b0;
            wait_cnt         <= '0;
`endif
        end else begin
            state         <= next_state;
            beat          <= next_beat;
            req_ready     <= (next_state == ST_IDLE);
            busy          <= (next_state != ST_IDLE);
            rsp_valid     <= (next_state == ST_RESP);
            core_key_en   <= (next_state == ST_KEY) ? beat_strobe(next_beat) : 4'h0;
            core_iv_en    <= (next_state == ST_IV)  ? beat_strobe(next_beat) : 4'h0;
            core_write_en <= (next_state == ST_DATA);
            core_addr     <= (next_state == ST_DATA) ? next_beat : 2'd0;
            core_start    <= (next_state == ST_START);

            if (state == ST_IDLE && accept) begin
                load_iv_q        <= req_load_iv;
                load_data_q      <= req_load_data;
                iv_q             <= req_iv;
                data_q           <= req_data;
                core_op_mode     <= req_op_mode;
                core_aes_mode    <= req_aes_mode;
                core_first_block <= req_first_block;
            end

            // Leaving WAIT without core_done can only be the timeout path.
            if (state == ST_WAIT && next_state == ST_RESP) begin
                rsp_data  <= core_done ? core_dout : '0;
`ifdef AES_HOST_TIMEOUT_EN
                rsp_error <= !core_done;
`endif
            end

            if (state == ST_RESP && rsp_ready) begin
                core_op_mode     <= 2'd0;
                core_aes_mode    <= 2'd0;
                core_first_block <= 1'b0;
                rsp_data         <= '0;
`ifdef AES_HOST_TIMEOUT_EN
                rsp_error        <= 1'b0;
`endif
            end

`ifdef AES_HOST_TIMEOUT_EN
            if (state == ST_START) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
`endif
        end
    end

`ifndef AES_HOST_TIMEOUT_EN
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_aes_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_host_sequencer
// Directed bench for aes_host_sequencer. The bench plays the role of aes_core:
// it drives core_done/core_dout by hand with known AES results and checks the
// load-bus beats, start timing, response handshake, backpressure, mid-job
// reset and (with AES_HOST_TIMEOUT_EN) the WAIT timeout.
// -----------------------------------------------------------------------------
module tb_aes_host_sequencer;
    import aes_host_pkg::*;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op_mode;
    logic [1:0]   req_aes_mode;
    logic         req_first_block;
    logic         req_load_key;
    logic         req_load_iv;
    logic         req_load_data;
    logic [127:0] req_key;
    logic [127:0] req_iv;
    logic [127:0] req_data;
    logic [31:0]  core_bus_in;
    logic [3:0]   core_key_en;
    logic [3:0]   core_iv_en;
    logic [1:0]   core_addr;
    logic         core_write_en;
    logic [1:0]   core_op_mode;
    logic [1:0]   core_aes_mode;
    logic         core_first_block;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_dout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic         busy;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    logic [1:0] exp_op;
    logic [1:0] exp_aes;
    logic       exp_first;

    localparam logic [127:0] FIPS_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SP_KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_DERIVED = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SP_IV      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SP_PT1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_CT1     = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] SP_PT2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] SP_CT2     = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] ECB_IV     = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

    aes_host_sequencer #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op_mode      (req_op_mode),
        .req_aes_mode     (req_aes_mode),
        .req_first_block  (req_first_block),
        .req_load_key     (req_load_key),
        .req_load_iv      (req_load_iv),
        .req_load_data    (req_load_data),
        .req_key          (req_key),
        .req_iv           (req_iv),
        .req_data         (req_data),
        .core_bus_in      (core_bus_in),
        .core_key_en      (core_key_en),
        .core_iv_en       (core_iv_en),
        .core_addr        (core_addr),
        .core_write_en    (core_write_en),
        .core_op_mode     (core_op_mode),
        .core_aes_mode    (core_aes_mode),
        .core_first_block (core_first_block),
        .core_start       (core_start),
        .core_done        (core_done),
        .core_dout        (core_dout),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_error        (rsp_error),
        .busy             (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and sample just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts, asserts, reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present a job for one accepting edge; afterwards the bench sits in cycle 1.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] aes_m,
                                 input logic first, input logic lk, input logic li,
                                 input logic ld, input logic [127:0] key,
                                 input logic [127:0] iv, input logic [127:0] data);
        req_op_mode     = op;
        req_aes_mode    = aes_m;
        req_first_block = first;
        req_load_key    = lk;
        req_load_iv     = li;
        req_load_data   = ld;
        req_key         = key;
        req_iv          = iv;
        req_data        = data;
        req_valid       = 1'b1;
        exp_op          = op;
        exp_aes         = aes_m;
        exp_first       = first;
        checkOutput("req_ready before accept", {127'd0, req_ready}, 128'd1);
        step();
        req_valid       = 1'b0;
        req_key         = '0;
        req_iv          = '0;
        req_data        = '0;
    endtask

    // Four beats of one load phase: phase 0 key, 1 IV, 2 data.
    task automatic checkPhase(input string tag, input int phase, input logic [127:0] op);
        logic [31:0] word;
        logic [3:0]  onehot;
        for (int i = 0; i < 4; i++) begin
            word   = op[127-32*i -: 32];
            onehot = 4'(1 << i);
            checkOutput($sformatf("%s beat%0d bus", tag, i), {96'd0, core_bus_in}, {96'd0, word});
            checkOutput($sformatf("%s beat%0d key_en", tag, i), {124'd0, core_key_en},
                        (phase == 0) ? {124'd0, onehot} : 128'd0);
            checkOutput($sformatf("%s beat%0d iv_en", tag, i), {124'd0, core_iv_en},
                        (phase == 1) ? {124'd0, onehot} : 128'd0);
            checkOutput($sformatf("%s beat%0d write_en", tag, i), {127'd0, core_write_en},
                        (phase == 2) ? 128'd1 : 128'd0);
            checkOutput($sformatf("%s beat%0d addr", tag, i), {126'd0, core_addr},
                        (phase == 2) ? 128'(i) : 128'd0);
            checkOutput($sformatf("%s beat%0d start", tag, i), {127'd0, core_start}, 128'd0);
            checkOutput($sformatf("%s beat%0d op_mode", tag, i), {126'd0, core_op_mode}, {126'd0, exp_op});
            checkOutput($sformatf("%s beat%0d busy", tag, i), {127'd0, busy}, 128'd1);
            step();
        end
    endtask

    // Start cycle: single pulse, idle bus; returns in the first WAIT cycle.
    task automatic checkStart(input string tag);
        checkOutput({tag, " start pulse"}, {127'd0, core_start}, 128'd1);
        checkOutput({tag, " start strobes"},
                    {119'd0, core_key_en, core_iv_en, core_write_en}, 128'd0);
        checkOutput({tag, " start bus"}, {96'd0, core_bus_in}, 128'd0);
        step();
        checkOutput({tag, " start dropped"}, {127'd0, core_start}, 128'd0);
        checkOutput({tag, " wait no rsp"}, {127'd0, rsp_valid}, 128'd0);
    endtask

    // Core signals completion for one cycle; returns one cycle later.
    task automatic giveDone(input logic [127:0] result);
        core_done = 1'b1;
        core_dout = result;
        step();
        core_done = 1'b0;
        core_dout = '0;
    endtask

    task automatic checkResp(input string tag, input logic [127:0] exp_data);
        checkOutput({tag, " rsp_valid"}, {127'd0, rsp_valid}, 128'd1);
        checkOutput({tag, " rsp_data"}, rsp_data, exp_data);
        checkOutput({tag, " rsp_error"}, {127'd0, rsp_error}, 128'd0);
        checkOutput({tag, " req_ready in resp"}, {127'd0, req_ready}, 128'd0);
        checkOutput({tag, " modes held"}, {123'd0, core_op_mode, core_aes_mode, core_first_block},
                    {123'd0, exp_op, exp_aes, exp_first});
    endtask

    // Accept the response; req_ready must return the following cycle.
    task automatic finishResp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput({tag, " req_ready after rsp"}, {127'd0, req_ready}, 128'd1);
        checkOutput({tag, " rsp_valid cleared"}, {127'd0, rsp_valid}, 128'd0);
        checkOutput({tag, " busy cleared"}, {127'd0, busy}, 128'd0);
    endtask

    // Linear sequence of directed steps.
    initial begin
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_op_mode     = 2'd0;
        req_aes_mode    = 2'd0;
        req_first_block = 1'b0;
        req_load_key    = 1'b0;
        req_load_iv     = 1'b0;
        req_load_data   = 1'b0;
        req_key         = '0;
        req_iv          = '0;
        req_data        = '0;
        core_done       = 1'b0;
        core_dout       = '0;
        rsp_ready       = 1'b0;
        exp_op          = 2'd0;
        exp_aes         = 2'd0;
        exp_first       = 1'b0;

        $display("[TB] reset");
        step();
        step();
        checkOutput("reset req_ready", {127'd0, req_ready}, 128'd0);
        checkOutput("reset busy", {127'd0, busy}, 128'd0);
        checkOutput("reset rsp_valid", {127'd0, rsp_valid}, 128'd0);
        checkOutput("reset bus", {96'd0, core_bus_in}, 128'd0);
        checkOutput("reset strobes", {118'd0, core_key_en, core_iv_en, core_write_en, core_start}, 128'd0);
        rst = 1'b0;
        step();
        checkOutput("post-reset req_ready", {127'd0, req_ready}, 128'd1);
        checkOutput("post-reset busy", {127'd0, busy}, 128'd0);

        $display("[TB] ECB encrypt, all loads");
        applyStimulus(ENCRYPTION, ECB, 1'b1, 1'b1, 1'b1, 1'b1, FIPS_KEY, ECB_IV, FIPS_PT);
        checkPhase("ecb key", 0, FIPS_KEY);
        checkPhase("ecb iv", 1, ECB_IV);
        checkPhase("ecb data", 2, FIPS_PT);
        core_done = 1'b1;
        core_dout = '1;
        checkStart("ecb");
        core_done = 1'b0;
        core_dout = '0;
        step();
        step();
        checkOutput("ecb done in start ignored", {127'd0, rsp_valid}, 128'd0);
        giveDone(FIPS_CT);
        checkResp("ecb", FIPS_CT);
        finishResp("ecb");

        $display("[TB] key derivation with backpressure");
        applyStimulus(KEY_DERIVATION, ECB, 1'b1, 1'b1, 1'b0, 1'b0, SP_KEY, '0, '0);
        checkPhase("kd key", 0, SP_KEY);
        checkStart("kd");
        giveDone(SP_DERIVED);
        checkResp("kd", SP_DERIVED);
        for (int c = 0; c < 20; c++) begin
            step();
            checkOutput($sformatf("bp%0d rsp_valid", c), {127'd0, rsp_valid}, 128'd1);
            checkOutput($sformatf("bp%0d rsp_data", c), rsp_data, SP_DERIVED);
            checkOutput($sformatf("bp%0d req_ready", c), {127'd0, req_ready}, 128'd0);
            checkOutput($sformatf("bp%0d strobes", c),
                        {118'd0, core_key_en, core_iv_en, core_write_en, core_start}, 128'd0);
        end
        finishResp("kd");

        $display("[TB] CBC encrypt, two blocks");
        applyStimulus(ENCRYPTION, CBC, 1'b1, 1'b1, 1'b1, 1'b1, SP_KEY, SP_IV, SP_PT1);
        checkPhase("cbc1 key", 0, SP_KEY);
        checkPhase("cbc1 iv", 1, SP_IV);
        checkPhase("cbc1 data", 2, SP_PT1);
        checkStart("cbc1");
        giveDone(SP_CT1);
        checkResp("cbc1", SP_CT1);
        finishResp("cbc1");
        applyStimulus(ENCRYPTION, CBC, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, SP_PT2);
        checkPhase("cbc2 data", 2, SP_PT2);
        checkStart("cbc2");
        giveDone(SP_CT2);
        checkResp("cbc2", SP_CT2);
        finishResp("cbc2");

        $display("[TB] no loads, start at cycle 1");
        applyStimulus(DECRYPTION, CTR, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checkStart("noload");
`ifdef AES_HOST_TIMEOUT_EN
        repeat (7) step();
        checkOutput("timeout not yet", {127'd0, rsp_valid}, 128'd0);
        step();
        checkOutput("timeout rsp_valid", {127'd0, rsp_valid}, 128'd1);
        checkOutput("timeout rsp_error", {127'd0, rsp_error}, 128'd1);
        checkOutput("timeout rsp_data", rsp_data, 128'd0);
`else
        repeat (20) step();
        checkOutput("unbounded wait rsp_valid", {127'd0, rsp_valid}, 128'd0);
        checkOutput("unbounded wait busy", {127'd0, busy}, 128'd1);
        giveDone(SP_CT2);
        checkResp("noload", SP_CT2);
`endif
        finishResp("noload");

        $display("[TB] reset during IV beat 2");
        applyStimulus(ENCRYPTION, ECB, 1'b1, 1'b1, 1'b1, 1'b1, FIPS_KEY, ECB_IV, FIPS_PT);
        checkPhase("rst key", 0, FIPS_KEY);
        step();
        step();
        checkOutput("rst at iv beat2", {124'd0, core_iv_en}, 128'h4);
        rst = 1'b1;
        step();
        checkOutput("rst busy", {127'd0, busy}, 128'd0);
        checkOutput("rst bus", {96'd0, core_bus_in}, 128'd0);
        checkOutput("rst strobes", {118'd0, core_key_en, core_iv_en, core_write_en, core_start}, 128'd0);
        checkOutput("rst modes", {123'd0, core_op_mode, core_aes_mode, core_first_block}, 128'd0);
        checkOutput("rst rsp_valid", {127'd0, rsp_valid}, 128'd0);
        rst = 1'b0;
        step();
        checkOutput("rst recover req_ready", {127'd0, req_ready}, 128'd1);
        applyStimulus(ENCRYPTION, ECB, 1'b1, 1'b1, 1'b1, 1'b1, FIPS_KEY, ECB_IV, FIPS_PT);
        checkPhase("ecb2 key", 0, FIPS_KEY);
        checkPhase("ecb2 iv", 1, ECB_IV);
        checkPhase("ecb2 data", 2, FIPS_PT);
        checkStart("ecb2");
        giveDone(FIPS_CT);
        checkResp("ecb2", FIPS_CT);
        finishResp("ecb2");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/aes_host_sequencer.md
# aes_host_sequencer

Host-side initiator for `aes_core`'s 32-bit load bus. It accepts one 128-bit job (key, IV, data, mode) over a valid/ready handshake and serializes the key, IV and data words onto the core's `key_en`/`iv_en`/`addr`+`write_en` strobes. It then pulses `start`, waits for the core's completion indication and returns the 128-bit result over a second valid/ready handshake. It sits between a system bus or DMA front end and `aes_core`, replacing hand-driven load sequences.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum WAIT cycles before an error response. Only used with `AES_HOST_TIMEOUT_EN`.

Ports (reset is synchronous, active-high; one clock):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1, `req_ready` out 1: job handshake.
- `req_op_mode` in 2: 00 ENCRYPTION, 01 KEY_DERIVATION, 10 DECRYPTION, 11 DECRYP_W_DERIV.
- `req_aes_mode` in 2: 00 ECB, 01 CBC, 10 CTR.
- `req_first_block` in 1: forwarded as `first_block`.
- `req_load_key`, `req_load_iv`, `req_load_data` in 1 each: enable the corresponding load phase.
- `req_key`, `req_iv`, `req_data` in 128 each: job operands.
- `core_bus_in` out 32: word driven to the core.
- `core_key_en`, `core_iv_en` out 4: one-hot word strobes.
- `core_addr` out 2: data word index.
- `core_write_en` out 1: data word strobe.
- `core_op_mode`, `core_aes_mode` out 2 each; `core_first_block` out 1.
- `core_start` out 1: one-cycle start pulse.
- `core_done` in 1: core returned to idle, result valid.
- `core_dout` in 128: result (block, or derived key for KEY_DERIVATION).
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out 128, `rsp_error` out 1: result handshake.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, KEY, IV, DATA, START, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid&&req_ready`, register all `req_*` fields and go to the first enabled load phase, in the order KEY, IV, DATA. If no load phase is enabled, go to START.
- Each load phase is exactly 4 beats, one per cycle, MSB word first: beat i drives `core_bus_in`=operand[127-32i -: 32].
  - KEY: `core_key_en`=4'b0001, 0010, 0100, 1000.
  - IV: `core_iv_en` uses the same one-hot pattern.
  - DATA: `core_write_en`=1 with `core_addr`=0..3.
  - Phases run back to back with no gap cycles. A 2-bit beat counter wraps 3→0 on phase exit.
- START: `core_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: `core_done` is sampled only in this state. A `core_done` asserted during START is ignored. On `core_done`, capture `core_dout` into `rsp_data`, set `rsp_error`=0 and go to RESP.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_error` hold stable until `rsp_ready`; then go to IDLE. `req_ready`=0 here, so no overlap between jobs.
- `core_op_mode`, `core_aes_mode` and `core_first_block` drive the registered values from accept until the RESP handshake completes.
- Idle outputs: all strobes 0 and `core_bus_in`=0.

## Timing
- Reset values: all outputs 0 (`req_ready`=0 during reset, 1 from the first cycle after reset deasserts), state IDLE.
- Cycle 0: request accepted. With all three loads enabled:
  - key beats at cycles 1–4;
  - IV beats at cycles 5–8;
  - data beats at cycles 9–12;
  - `core_start` at cycle 13.
  - Disabled phases are skipped; with no loads, start is at cycle 1.
- `core_done` at cycle N in WAIT → `rsp_valid` at N+1.
- Response accepted at cycle M → `req_ready` at M+1.
- `rst` mid-job: the next edge returns to IDLE and zeroes all outputs. The in-flight job is dropped with no response, and the core must be reset alongside.

## Configuration
- `AES_HOST_TIMEOUT_EN` defined: a WAIT cycle counter that clears on WAIT entry. When it reaches `TIMEOUT_CYCLES` without `core_done`, go to RESP with `rsp_error`=1 and `rsp_data`=0.
- Undefined: WAIT has no bound, `rsp_error` is tied to 0 and the counter is absent.

## Structure
- Package `aes_host_pkg` holds:
  - the state enum;
  - the op_mode constants (ENCRYPTION, KEY_DERIVATION, DECRYPTION, DECRYP_W_DERIV);
  - the aes_mode constants (ECB, CBC, CTR);
  - the one-hot beat-strobe decode function.
- Sub-module `aes_host_word_shift`: loads 128 bits and presents words MSB-first, advancing one word per enabled beat. It is used by all three load phases.

## Test plan
- ECB encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, all loads enabled.
  - Key beats 00010203/04050607/08090a0b/0c0d0e0f with strobes 0001→1000.
  - `core_start` at cycle 13.
  - `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- KEY_DERIVATION with key 2b7e151628aed2a6abf7158809cf4f3c, key load only: start at cycle 5; `rsp_data` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- CBC encrypt, 2 blocks:
  - Block 1 (key, IV, first_block=1): `rsp_data` = 7649abac8119b246cee98e9b12e9197d.
  - Block 2 (data only, first_block=0): `rsp_data` = 5086cb9b507219ee95db113a917678b2.
- Backpressure: hold `rsp_ready`=0 for 20 cycles → `rsp_valid` and `rsp_data` stable, `req_ready`=0, no strobes.
- Timeout (macro on, TIMEOUT_CYCLES=8, `core_done` never asserted) → `rsp_valid` with `rsp_error`=1 and `rsp_data`=0 after 8 WAIT cycles.
- `rst` asserted at IV beat 2 → next cycle all outputs 0 and `busy`=0; a fresh ECB job then produces the correct result.
